// File: rtl/matrix_unswap_decoder.sv
// Inverse 5x5 lane-permutation decoder: out_line[j] = in_line[P(j)], valid/ready in and out.
// Define MATRIX_UNSWAP_PARALLEL_EN for a single-cycle combinational permute (no PERM state).
module matrix_unswap_decoder #(
  parameter int OFFSET = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_line,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_line,
  output logic             busy,
  output logic [CNT_W-1:0] line_count
);

  // Source coordinate for destination bit j; all mods folded into 0..4.
  function automatic logic [4:0] perm_of(input int j);
    int x, y, xx, yy, nx, ny;
    x  = j % 5;
    y  = j / 5;
    xx = (x + OFFSET) % 5;
    yy = (y + OFFSET) % 5;
    nx = (((yy - OFFSET) % 5) + 5) % 5;
    ny = (((((2 * xx) + (3 * yy)) % 5 - OFFSET) % 5) + 5) % 5;
    return 5'(5 * ny + nx);
  endfunction

  logic [4:0] p_tab [25];
  for (genvar j = 0; j < 25; j++) begin : g_tab
    assign p_tab[j] = perm_of(j);
  end

`ifdef MATRIX_UNSWAP_PARALLEL_EN
  typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;

  logic [24:0] inv_line;
  for (genvar j = 0; j < 25; j++) begin : g_inv
    assign inv_line[j] = in_line[p_tab[j]];
  end
`else
  typedef enum logic [1:0] {S_IDLE, S_PERM, S_HOLD} state_t;

  logic [24:0] src_q, src_d;
  logic [4:0]  idx_q, idx_d;
`endif

  state_t           state_q, state_d;
  logic [24:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dst_q   <= '0;
      cnt_q   <= '0;
`ifndef MATRIX_UNSWAP_PARALLEL_EN
      src_q   <= '0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
`ifndef MATRIX_UNSWAP_PARALLEL_EN
      src_q   <= src_d;
      idx_q   <= idx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifndef MATRIX_UNSWAP_PARALLEL_EN
    src_d     = src_q;
    idx_d     = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef MATRIX_UNSWAP_PARALLEL_EN
          dst_d   = inv_line;
          state_d = S_HOLD;
`else
          src_d   = in_line;
          dst_d   = '0;
          idx_d   = '0;
          state_d = S_PERM;
`endif
        end
      end
`ifndef MATRIX_UNSWAP_PARALLEL_EN
      S_PERM: begin
        busy         = 1'b1;
        dst_d[idx_q] = src_q[p_tab[idx_q]];
        idx_d        = idx_q + 5'd1;
        if (idx_q == 5'd24) begin
          idx_d   = '0;
          state_d = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // dst only changes on accept or during PERM, so out_line is stable through HOLD.
  assign out_line   = dst_q;
  assign line_count = cnt_q;

endmodule

// File: tb/tb_matrix_unswap_decoder.sv
// Directed and encoder-round-trip bench for matrix_unswap_decoder (OFFSET=3, CNT_W=8).
module tb_matrix_unswap_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_line;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_line;
  logic        busy;
  logic [7:0]  line_count;

  int checks   = 0;
  int failures = 0;

`ifdef MATRIX_UNSWAP_PARALLEL_EN
  localparam int LAT_EXP  = 0;
  localparam int BUSY_EXP = 0;
`else
  localparam int LAT_EXP  = 25;
  localparam int BUSY_EXP = 25;
`endif

  // Forward map for OFFSET=3, worked out by hand: P(j) = 5*((2x+3y+2)%5) + y.
  localparam int PT [25] = '{10, 20, 5, 15, 0,
                             1, 11, 21, 6, 16,
                             17, 2, 12, 22, 7,
                             8, 18, 3, 13, 23,
                             24, 9, 19, 4, 14};

  matrix_unswap_decoder #(.OFFSET(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_line    (in_line),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_line   (out_line),
    .busy       (busy),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] encode(input logic [24:0] orig);
    logic [24:0] e;
    e = '0;
    for (int j = 0; j < 25; j++) e[PT[j]] = orig[j];
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer a line, then sample #1 after each edge until out_valid rises.
  task automatic run_line(input logic [24:0] line, output logic [24:0] got,
                          output int lat, output int bcnt);
    @(negedge clk);
    in_valid = 1'b1;
    in_line  = line;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    got = out_line;
  endtask

  task automatic take_output();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [24:0] din;
    logic [24:0] dout;
    string       tag;
  } vec_t;

  vec_t vecs [4] = '{
    '{25'h0000400, 25'h0000001, "bit10"},
    '{25'h0100000, 25'h0000002, "bit20"},
    '{25'h0004000, 25'h1000000, "bit14"},
    '{25'h1FFFFFF, 25'h1FFFFFF, "ones"}
  };

  initial begin
    logic [24:0] got, held, orig;
    int lat, bcnt, bad;
    rst = 1'b1; in_valid = 1'b0; in_line = '0; out_ready = 1'b0;

    do_reset();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_line_count", 32'(line_count), 32'd0);
    check_val("rst_out_line", 32'(out_line), 32'd0);

    // Reset mid-PERM (mid-HOLD in the parallel build) drops the line.
    @(negedge clk);
    in_valid = 1'b1;
    in_line  = 25'h0ABCDEF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat ((LAT_EXP > 0) ? 12 : 0) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_line_count", 32'(line_count), 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_line(vecs[v].din, got, lat, bcnt);
      check_val({vecs[v].tag, "_data"}, 32'(got), 32'(vecs[v].dout));
      check_val({vecs[v].tag, "_latency"}, 32'(lat), 32'(LAT_EXP));
      check_val({vecs[v].tag, "_busy_cycles"}, 32'(bcnt), 32'(BUSY_EXP));
      take_output();
      check_val({vecs[v].tag, "_count"}, 32'(line_count), 32'(v + 1));
      check_val({vecs[v].tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check_val({vecs[v].tag, "_valid_fall"}, 32'(out_valid), 32'd0);
    end

    // Back-pressure in HOLD: output frozen, input ignored.
    run_line(encode(25'h1234567), got, lat, bcnt);
    check_val("hold_data", 32'(got), 32'h1234567);
    held = got;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_line  = 25'($urandom);
      @(posedge clk);
      #1;
      check_val("hold_stable", 32'(out_line), 32'(held));
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_output();
    check_val("hold_count", 32'(line_count), 32'd5);
    check_val("hold_back_idle", 32'(in_ready), 32'd1);
    check_val("hold_valid_fall", 32'(out_valid), 32'd0);

    // out_ready while idle must not count.
    take_output();
    check_val("idle_ready_no_count", 32'(line_count), 32'd5);

    // 300-line round trip through the encoder model; count wraps past 255.
    do_reset();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      orig = 25'($urandom);
      run_line(encode(orig), got, lat, bcnt);
      if (got !== orig || lat != LAT_EXP) bad++;
      take_output();
    end
    check_val("roundtrip_bad_lines", 32'(bad), 32'd0);
    check_val("roundtrip_count", 32'(line_count), 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
